// File: rtl/sysarr_pkg.sv
// Shared constants, FSM state encoding and bus helpers for the systolic-array operand feeder.
package sysarr_pkg;
    localparam int N = 4;
    localparam int W = 32;
    localparam int K = 4;
    localparam int BW = $clog2(K + N);
    localparam int AW = 2 * $clog2(N);
    localparam logic [BW-1:0] LAST_BEAT = BW'(K + N - 2);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT, DONE} state_t;

    // Word carried on one lane of an N-lane bus.
    function automatic logic [W-1:0] lane_slice(input logic [N*W-1:0] bus, input int lane);
        return bus[lane*W +: W];
    endfunction
endpackage

// File: rtl/sysarr_skew_lane.sv
// One skewed lane: beat t carries word k = t - LANE when 0 <= k < K, otherwise zero.
module sysarr_skew_lane
    import sysarr_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic [BW-1:0]  beat,
    input  logic [K*W-1:0] words,
    output logic [W-1:0]   word
);
    localparam logic [BW-1:0] LANE_B = BW'(LANE);
    localparam logic [BW-1:0] K_B = BW'(K);

    logic [BW-1:0] k_idx;

    always_comb begin
        k_idx = beat - LANE_B;
        word  = '0;
        if ((beat >= LANE_B) && (k_idx < K_B)) begin
            word = words[int'(k_idx)*W +: W];
        end
    end
endmodule

// File: rtl/sysarr_feeder.sv
// Operand feeder for the 4x4 systolic array: tile storage, job FSM, skewed operand streaming.
module sysarr_feeder
    import sysarr_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic           wr_sel,
    input  logic [AW-1:0]  wr_addr,
    input  logic [W-1:0]   wr_data,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           g_rst,
    output logic           dataReady,
    output logic [N*W-1:0] dataAIn,
    output logic [N*W-1:0] dataBIn,
    input  logic           jobDone,
    output state_t         fsm_state
);
    state_t        state, state_next;
    logic [BW-1:0] beat, beat_next;

    logic [W-1:0]   tile_a [N*N];
    logic [W-1:0]   tile_b [N*N];
    logic [K*W-1:0] a_words [N];
    logic [K*W-1:0] b_words [N];
    logic [N*W-1:0] a_bus_next, b_bus_next;

    // Tile storage deliberately has no reset so contents survive a mid-job reset.
    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE)) begin
            if (wr_sel) tile_b[wr_addr] <= wr_data;
            else        tile_a[wr_addr] <= wr_data;
        end
    end

    // A lanes walk down a column of A, B lanes walk along a row of B.
    for (genvar lane = 0; lane < N; lane++) begin : g_lane
        for (genvar k = 0; k < K; k++) begin : g_word
            assign a_words[lane][k*W +: W] = tile_a[k*N + lane];
            assign b_words[lane][k*W +: W] = tile_b[lane*N + k];
        end
        sysarr_skew_lane #(.LANE(lane)) u_lane_a (
            .beat  (beat_next),
            .words (a_words[lane]),
            .word  (a_bus_next[lane*W +: W])
        );
        sysarr_skew_lane #(.LANE(lane)) u_lane_b (
            .beat  (beat_next),
            .words (b_words[lane]),
            .word  (b_bus_next[lane*W +: W])
        );
    end

    always_comb begin
        state_next = state;
        beat_next  = beat;
        case (state)
            IDLE:   if (start) state_next = CLEAR;
            CLEAR: begin
                state_next = STREAM;
                beat_next  = '0;
            end
            STREAM: begin
                if (beat == LAST_BEAT) state_next = WAIT;
                else                   beat_next  = beat + 1'b1;
            end
            WAIT:   if (jobDone) state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            beat      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            g_rst     <= 1'b0;
            dataReady <= 1'b0;
            dataAIn   <= '0;
            dataBIn   <= '0;
        end else begin
            state     <= state_next;
            beat      <= beat_next;
            busy      <= (state_next == CLEAR) || (state_next == STREAM) || (state_next == WAIT);
            done      <= (state_next == DONE);
            g_rst     <= (state_next == CLEAR);
            dataReady <= (state_next == STREAM);
            dataAIn   <= (state_next == STREAM) ? a_bus_next : '0;
            dataBIn   <= (state_next == STREAM) ? b_bus_next : '0;
        end
    end

    assign fsm_state = state;
endmodule

// File: tb/tb_sysarr_feeder.sv
// Directed bench for sysarr_feeder with a small propagating systolic-array model.
module tb_sysarr_feeder;
    import sysarr_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           wr_en = 1'b0;
    logic           wr_sel = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [W-1:0]   wr_data = '0;
    logic           start = 1'b0;
    logic           jobDone = 1'b0;
    logic           busy, done, g_rst, dataReady;
    logic [N*W-1:0] dataAIn, dataBIn;
    state_t         fsm_state;

    int tests = 0;
    int fails = 0;
    logic [N*W-1:0] exp_q[$];
    logic [W-1:0]   a_mirror [N*N];
    logic [W-1:0]   b_mirror [N*N];

    sysarr_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .g_rst     (g_rst),
        .dataReady (dataReady),
        .dataAIn   (dataAIn),
        .dataBIn   (dataBIn),
        .jobDone   (jobDone),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    // Array model: A flows down columns, B flows across rows, each station multiply-accumulates.
    logic [63:0]  acc    [N][N];
    logic [W-1:0] a_pipe [N][N];
    logic [W-1:0] b_pipe [N][N];
    logic [W-1:0] a_nxt  [N][N];
    logic [W-1:0] b_nxt  [N][N];
    logic [W-1:0] a_in, b_in;

    always @(negedge clk) begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (!rst || g_rst) begin
                    acc[r][c] = '0;
                    a_nxt[r][c] = '0;
                    b_nxt[r][c] = '0;
                end else begin
                    a_in = (r == 0) ? lane_slice(dataAIn, c) : a_pipe[r-1][c];
                    b_in = (c == 0) ? lane_slice(dataBIn, r) : b_pipe[r][c-1];
                    acc[r][c] = acc[r][c] + 64'(a_in) * 64'(b_in);
                    a_nxt[r][c] = a_in;
                    b_nxt[r][c] = b_in;
                end
            end
        end
        a_pipe = a_nxt;
        b_pipe = b_nxt;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic sel, input int row, input int col, input logic [W-1:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(row * N + col);
        wr_data = data;
        step();
        wr_en = 1'b0;
        if (sel) b_mirror[row*N + col] = data;
        else     a_mirror[row*N + col] = data;
    endtask

    task automatic start_job();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [N*W-1:0] exp_a_bus(input int t);
        logic [N*W-1:0] bus = '0;
        for (int c = 0; c < N; c++) begin
            if ((t - c >= 0) && (t - c < K)) bus[c*W +: W] = a_mirror[(t-c)*N + c];
        end
        return bus;
    endfunction

    function automatic logic [N*W-1:0] exp_b_bus(input int t);
        logic [N*W-1:0] bus = '0;
        for (int r = 0; r < N; r++) begin
            if ((t - r >= 0) && (t - r < K)) bus[r*W +: W] = b_mirror[r*N + (t-r)];
        end
        return bus;
    endfunction

    // Called while in WAIT: raise jobDone, expect the one-cycle done pulse, then IDLE.
    task automatic finish_job(input string tag);
        jobDone = 1'b1;
        step();
        check({tag, "_done"}, 128'(done), 128'(1'b1));
        check({tag, "_busy_low"}, 128'(busy), 128'(1'b0));
        jobDone = 1'b0;
        step();
        check({tag, "_done_drop"}, 128'(done), 128'(1'b0));
        check({tag, "_idle"}, 128'(fsm_state), 128'(IDLE));
    endtask

    initial begin
        #100000;
        fails++;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        step();
        step();
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_done", 128'(done), 128'(1'b0));
        check("rst_g_rst", 128'(g_rst), 128'(1'b0));
        check("rst_ready", 128'(dataReady), 128'(1'b0));
        check("rst_a_bus", dataAIn, '0);
        check("rst_b_bus", dataBIn, '0);
        check("rst_state", 128'(fsm_state), 128'(IDLE));
        rst = 1'b1;
        step();

        // Identity job: A = I, B[r][k] = r*4+k+1
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                write_word(1'b0, r, c, (r == c) ? 32'd1 : 32'd0);
                write_word(1'b1, r, c, 32'(r * 4 + c + 1));
            end
        end
        start_job();
        check("id_clear_state", 128'(fsm_state), 128'(CLEAR));
        check("id_clear_g_rst", 128'(g_rst), 128'(1'b1));
        check("id_clear_ready", 128'(dataReady), 128'(1'b0));
        check("id_clear_busy", 128'(busy), 128'(1'b1));
        for (int t = 0; t < K + N - 1; t++) begin
            step();
            check($sformatf("id_ready_t%0d", t), 128'(dataReady), 128'(1'b1));
            check($sformatf("id_g_rst_t%0d", t), 128'(g_rst), 128'(1'b0));
            check($sformatf("id_a_t%0d", t), dataAIn, exp_a_bus(t));
            check($sformatf("id_b_t%0d", t), dataBIn, exp_b_bus(t));
        end
        step();
        check("id_wait_state", 128'(fsm_state), 128'(WAIT));
        check("id_wait_ready", 128'(dataReady), 128'(1'b0));
        check("id_wait_a", dataAIn, '0);
        check("id_wait_b", dataBIn, '0);
        for (int i = 0; i < 10; i++) step();
        finish_job("id");
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                check($sformatf("id_acc_%0d_%0d", r, c), 128'(acc[r][c]), 128'(r * 4 + c + 1));
            end
        end

        // Skew pattern A[k][c] = 0x100*k + c, with a dropped write mid-stream
        for (int k = 0; k < K; k++) begin
            for (int c = 0; c < N; c++) write_word(1'b0, k, c, 32'(256 * k + c));
        end
        for (int t = 0; t < K + N - 1; t++) exp_q.push_back(exp_a_bus(t));
        start_job();
        for (int t = 0; t < K + N - 1; t++) begin
            step();
            if (t == 1) wr_en = 1'b0;
            check($sformatf("skew_a_t%0d", t), dataAIn, exp_q.pop_front());
            if (t == 0) check("skew_beat0", dataAIn, 128'h0);
            if (t == 3) check("skew_beat3", dataAIn, 128'h00000003_00000102_00000201_00000300);
            if (t == 6) check("skew_beat6", dataAIn, 128'h00000303_00000000_00000000_00000000);
            if (t == 0) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = AW'(5);
                wr_data = 32'hDEAD;
            end
        end
        step();
        check("guard_wait", 128'(fsm_state), 128'(WAIT));
        start = 1'b1;
        step();
        start = 1'b0;
        check("guard_start_in_wait", 128'(fsm_state), 128'(WAIT));
        finish_job("guard");
        for (int i = 0; i < 3; i++) step();
        check("guard_no_rerun_busy", 128'(busy), 128'(1'b0));
        check("guard_no_rerun_state", 128'(fsm_state), 128'(IDLE));

        // Reset mid-STREAM, then a full job on the retained tiles
        start_job();
        step();
        step();
        step();
        check("mid_stream", 128'(fsm_state), 128'(STREAM));
        rst = 1'b0;
        #1;
        check("arst_async_ready", 128'(dataReady), 128'(1'b0));
        step();
        step();
        check("arst_busy", 128'(busy), 128'(1'b0));
        check("arst_ready", 128'(dataReady), 128'(1'b0));
        check("arst_a_bus", dataAIn, '0);
        check("arst_b_bus", dataBIn, '0);
        check("arst_state", 128'(fsm_state), 128'(IDLE));
        rst = 1'b1;
        step();
        start_job();
        check("rerun_clear", 128'(fsm_state), 128'(CLEAR));
        for (int t = 0; t < K + N - 1; t++) begin
            step();
            check($sformatf("rerun_a_t%0d", t), dataAIn, exp_a_bus(t));
            check($sformatf("rerun_b_t%0d", t), dataBIn, exp_b_bus(t));
            if (t == 2) check("guard_word_kept", 128'(lane_slice(dataAIn, 1)), 128'(32'h101));
        end
        step();
        finish_job("rerun");

        // Stale jobDone: WAIT still lasts one cycle
        jobDone = 1'b1;
        start_job();
        for (int t = 0; t < K + N - 1; t++) step();
        step();
        check("stale_wait_state", 128'(fsm_state), 128'(WAIT));
        check("stale_wait_done", 128'(done), 128'(1'b0));
        step();
        check("stale_done", 128'(done), 128'(1'b1));
        jobDone = 1'b0;
        step();
        check("stale_idle", 128'(fsm_state), 128'(IDLE));

        // Late jobDone: 20 cycles in WAIT, then exactly one done pulse
        start_job();
        for (int t = 0; t < K + N - 1; t++) step();
        step();
        for (int i = 0; i < 20; i++) begin
            check($sformatf("late_wait_%0d", i), 128'({fsm_state, done}), 128'({WAIT, 1'b0}));
            step();
        end
        jobDone = 1'b1;
        step();
        check("late_done", 128'(done), 128'(1'b1));
        jobDone = 1'b0;
        step();
        check("late_done_once", 128'(done), 128'(1'b0));

        // Back-to-back start on the cycle after done, with a same-cycle write
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = AW'(0);
        wr_data = 32'h777;
        a_mirror[0] = 32'h777;
        step();
        start = 1'b0;
        wr_en = 1'b0;
        check("b2b_clear", 128'(fsm_state), 128'(CLEAR));
        check("b2b_g_rst", 128'(g_rst), 128'(1'b1));
        for (int t = 0; t < K + N - 1; t++) begin
            step();
            check($sformatf("b2b_a_t%0d", t), dataAIn, exp_a_bus(t));
            if (t == 0) check("b2b_write_first", 128'(lane_slice(dataAIn, 0)), 128'(32'h777));
        end
        step();
        finish_job("b2b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
